telemetre_sequencer: RTL and testbench
======================================

// Module: telemetre_sequencer
// PURPOSE
//   Sequences one ultrasonic range measurement around the divided carrier (Frq) from the frequency divider.
//   On Start: gates exactly BURST_PULSES full carrier periods onto the transducer drive.
//   Then blanks the receiver for ring-down and times the echo, ending on echo or timeout.
//   Sits between the divider and the distance/display logic; one measurement at a time.
// PARAMETERS
//   BURST_PULSES  8      full carrier periods per burst (>=1)
//   BLANK_CYCLES  1000   Clk cycles after burst end during which Echo is ignored
//   TIMEOUT       60000  max time count; no echo by then -> timeout (BLANK_CYCLES < TIMEOUT < 2**CNT_W)
//   CNT_W         16     width of time counter and Echo_time
// PORTS
//   Clk        in   1      system clock; all registers on rising edge
//   Rst_n      in   1      asynchronous reset, active low
//   Start      in   1      measurement request, level-sampled in IDLE
//   Frq_in     in   1      divided carrier square wave (asynchronous to Clk domain logic)
//   Echo       in   1      receiver comparator output, asynchronous
//   Burst_out  out  1      gated carrier to transducer driver
//   Busy       out  1      high from Start acceptance until Done cycle inclusive
//   Done       out  1      one-cycle pulse: measurement finished, results valid
//   Timeout    out  1      result flag: no echo (or no carrier), held until next Done
//   Echo_time  out  CNT_W  echo delay in Clk cycles, held until next Done
// BEHAVIOUR
//   - Frq_in and Echo pass through 2-FF synchronizers (Frq_s, Echo_s); edges are detected on synced signals vs 1-cycle delayed copy.
//   - Reset (async, any state): state=IDLE; Burst_out, Busy, Done, Timeout = 0; Echo_time = 0; counters = 0. Burst_out drops immediately.
//   - States: IDLE, ARM, BURST, BLANK, LISTEN, DONE.
//   - IDLE: Busy=0. Start=1 -> ARM, time counter T cleared to 0.
//   - ARM: waits for Frq_s rising edge, so the burst starts on a full period.
//     - T increments each cycle.
//     - Rising edge detected -> BURST, T loaded with 1, pulse counter P cleared.
//     - T reaches TIMEOUT first -> DONE with Timeout=1, Echo_time=TIMEOUT (carrier dead).
//   - BURST: Burst_out <= Frq_s (registered, one cycle behind Frq_s).
//     - P increments on each Frq_s falling edge.
//     - On the falling edge that makes P==BURST_PULSES -> BLANK. Burst_out is then 0 and stays 0 outside BURST.
//   - BLANK: Echo ignored; after exactly BLANK_CYCLES cycles in BLANK -> LISTEN.
//   - LISTEN: Echo_s rising edge -> DONE, Echo_time=T, Timeout=0.
//     - Otherwise at T==TIMEOUT -> DONE, Echo_time=TIMEOUT, Timeout=1.
//     - Echo edge in the same cycle as T==TIMEOUT: the echo wins (Timeout=0, Echo_time=TIMEOUT).
//     - Echo already high on entry to LISTEN (no rising edge) is not an echo.
//   - T: increments every cycle in BURST/BLANK/LISTEN and saturates at TIMEOUT. If T hits TIMEOUT during BURST/BLANK, finish with Timeout=1.
//   - Echo_time equals Clk cycles between the Frq_in rising edge starting the burst and the Echo rising edge, both measured at the pins. Synchronizer latency cancels.
//   - DONE: exactly one cycle; Done=1, Busy=1; Echo_time/Timeout updated on entry -> IDLE.
//   - Start while Busy is ignored. Start held high restarts from IDLE after one IDLE cycle.
// TESTING (BURST_PULSES=4, BLANK_CYCLES=20, TIMEOUT=200, CNT_W=16, Frq_in period 10 clk, 50% duty)
//   - Reset: Rst_n=0 mid-BURST -> Burst_out/Busy/Done/Timeout=0 same cycle; Echo_time=0; IDLE after release.
//   - Nominal: Start pulse; Echo rises 120 clk after burst-start Frq_in edge -> 4 Burst_out periods then low; Done one cycle; Echo_time=120, Timeout=0.
//   - Blanking: Echo pulse 45 clk after burst start (inside BLANK), then no echo -> pulse ignored; Done with Timeout=1, Echo_time=200.
//   - Carrier stuck low: Start, Frq_in=0 -> Burst_out never toggles; Done after 200 clk in ARM, Timeout=1, Echo_time=200.
//   - Start re-asserted mid-LISTEN -> ignored, single Done. Start held high -> back-to-back measurements, one IDLE cycle between.
//   - Echo edge on the cycle T==200 -> Timeout=0, Echo_time=200.

Source files
------------

// File: rtl/telemetre_sequencer_if.sv
// Bundles the sequencer's measurement-side signals.
// The master side (stimulus or system logic) drives Start and the two
// asynchronous pins, Frq_in and Echo. The slave side (the sequencer) returns
// the transducer drive, the status flags and the measured echo delay.
//   Start      master->slave  measurement request
//   Frq_in     master->slave  divided carrier square wave (asynchronous)
//   Echo       master->slave  receiver comparator output (asynchronous)
//   Burst_out  slave->master  gated carrier to the transducer driver
//   Busy       slave->master  measurement in progress, Done cycle included
//   Done       slave->master  one-cycle "results valid" pulse
//   Timeout    slave->master  no echo (or no carrier) in the last measurement
//   Echo_time  slave->master  echo delay in Clk cycles
interface telemetre_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Frq_in;
  logic             Echo;
  logic             Burst_out;
  logic             Busy;
  logic             Done;
  logic             Timeout;
  logic [CNT_W-1:0] Echo_time;

  modport master (
    output Start, Frq_in, Echo,
    input  Burst_out, Busy, Done, Timeout, Echo_time
  );

  modport slave (
    input  Start, Frq_in, Echo,
    output Burst_out, Busy, Done, Timeout, Echo_time
  );
endinterface

// File: rtl/telemetre_sequencer.sv
// Sequences one ultrasonic range measurement around the divided carrier.
// After a Start request it waits for a carrier rising edge. It then gates
// BURST_PULSES full carrier periods onto Burst_out. Next it blanks the receiver
// for BLANK_CYCLES so that transducer ring-down is not taken as an echo.
// Finally it waits for an echo rising edge. The measurement ends on that echo,
// or when the time count T reaches TIMEOUT.
// Ports:
//   Clk    system clock; all registers update on its rising edge
//   Rst_n  asynchronous reset, active low
//   bus    slave side of telemetre_sequencer_if (Start, Frq_in, Echo in;
//          Burst_out, Busy, Done, Timeout, Echo_time out)
module telemetre_sequencer #(
  parameter int BURST_PULSES = 8,
  parameter int BLANK_CYCLES = 1000,
  parameter int TIMEOUT      = 60000,
  parameter int CNT_W        = 16
) (
  input logic                  Clk,
  input logic                  Rst_n,
  telemetre_sequencer_if.slave bus
);

  localparam int P_W = $clog2(BURST_PULSES + 1);

  localparam logic [CNT_W-1:0] T_MAX      = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [P_W-1:0]   P_LAST     = P_W'(BURST_PULSES - 1);

  typedef enum logic [2:0] {IDLE, ARM, BURST, BLANK, LISTEN, DONE} state_e;

  state_e           state_q, state_d;
  logic             frq_s1_q, frq_s1_d, frq_s_q, frq_s_d, frq_dly_q, frq_dly_d;
  logic             echo_s1_q, echo_s1_d, echo_s_q, echo_s_d, echo_dly_q, echo_dly_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0] b_q, b_d;
  logic             burst_q, burst_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] echo_time_q, echo_time_d;

  logic             frq_rise, frq_fall, echo_rise, t_at_max;
  logic [CNT_W-1:0] t_inc;

  // Edge detection compares each synchronized signal with a copy delayed by
  // one cycle. Frq and Echo pass through identical synchronizers, so their
  // latency cancels when the two edges are subtracted into Echo_time.
  assign frq_rise  =  frq_s_q & ~frq_dly_q;
  assign frq_fall  = ~frq_s_q &  frq_dly_q;
  assign echo_rise =  echo_s_q & ~echo_dly_q;
  assign t_at_max  = (t_q == T_MAX);
  assign t_inc     = t_at_max ? t_q : t_q + 1'b1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.Start) state_d = ARM;
      ARM: begin
        if (frq_rise)      state_d = BURST;
        else if (t_at_max) state_d = DONE;
      end
      BURST: begin
        if (t_at_max)                       state_d = DONE;
        else if (frq_fall && p_q == P_LAST) state_d = BLANK;
      end
      BLANK: begin
        if (t_at_max)             state_d = DONE;
        else if (b_q == BLANK_LAST) state_d = LISTEN;
      end
      // An echo that arrives on the same cycle as the timeout still counts.
      LISTEN:  if (echo_rise || t_at_max) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, synchronizers and result registers.
  // T counts from the cycle after the burst-starting carrier edge, so T=1 on
  // the first BURST cycle. Echo_time latches T on entry to DONE. On a timeout
  // exit, T has saturated at TIMEOUT, so the same load covers both endings.
  always_comb begin
    frq_s1_d    = bus.Frq_in;
    frq_s_d     = frq_s1_q;
    frq_dly_d   = frq_s_q;
    echo_s1_d   = bus.Echo;
    echo_s_d    = echo_s1_q;
    echo_dly_d  = echo_s_q;
    t_d         = t_q;
    p_d         = p_q;
    b_d         = b_q;
    timeout_d   = timeout_q;
    echo_time_d = echo_time_q;
    // Burst_out is registered from the next state, so it follows Frq_s by
    // exactly one cycle from the first BURST cycle and is low outside BURST.
    burst_d     = (state_d == BURST) && frq_s_q;

    unique case (state_q)
      IDLE: t_d = '0;
      ARM: begin
        if (frq_rise) begin
          t_d = CNT_W'(1);
          p_d = '0;
        end else begin
          t_d = t_inc;
        end
      end
      BURST: begin
        t_d = t_inc;
        b_d = '0;
        if (frq_fall) p_d = p_q + 1'b1;
      end
      BLANK: begin
        t_d = t_inc;
        b_d = b_q + 1'b1;
      end
      LISTEN:  t_d = t_inc;
      default: ;
    endcase

    if (state_d == DONE) begin
      timeout_d   = !((state_q == LISTEN) && echo_rise);
      echo_time_d = t_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frq_s1_q    <= 1'b0;
      frq_s_q     <= 1'b0;
      frq_dly_q   <= 1'b0;
      echo_s1_q   <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_dly_q  <= 1'b0;
      t_q         <= '0;
      p_q         <= '0;
      b_q         <= '0;
      burst_q     <= 1'b0;
      timeout_q   <= 1'b0;
      echo_time_q <= '0;
    end else begin
      frq_s1_q    <= frq_s1_d;
      frq_s_q     <= frq_s_d;
      frq_dly_q   <= frq_dly_d;
      echo_s1_q   <= echo_s1_d;
      echo_s_q    <= echo_s_d;
      echo_dly_q  <= echo_dly_d;
      t_q         <= t_d;
      p_q         <= p_d;
      b_q         <= b_d;
      burst_q     <= burst_d;
      timeout_q   <= timeout_d;
      echo_time_q <= echo_time_d;
    end
  end

  always_comb begin
    bus.Busy      = (state_q != IDLE);
    bus.Done      = (state_q == DONE);
    bus.Burst_out = burst_q;
    bus.Timeout   = timeout_q;
    bus.Echo_time = echo_time_q;
  end

endmodule

// File: tb/tb_telemetre_sequencer.sv
// Self-checking bench for telemetre_sequencer.
// The carrier is a free-running 10-clock square wave whose phase can be changed.
// The echo is a single pin pulse placed relative to the burst-starting carrier edge.
// Expected results come from the measurement rules:
//   - The burst starts on the first carrier rising edge that the armed sequencer can see.
//   - An echo counts only if its rising edge falls inside the listen window.
//   - Echo_time is the pin-to-pin distance between the two edges.
module tb_telemetre_sequencer;

  localparam int BP    = 4;
  localparam int BLANK = 20;
  localparam int TO    = 200;
  localparam int CW    = 16;
  localparam int PER   = 10;
  localparam int HI    = 5;
  localparam int SYNC  = 2;
  // First echo offset the sequencer listens to. The burst ends on the falling
  // edge of its last period, then BLANK cycles are ignored.
  localparam int LISTEN_OPEN = (BP - 1) * PER + HI + BLANK + 1;
  localparam int NONE = 32'h3fff_0000;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  int cyc      = 0;
  int phase    = 0;
  bit frq_en   = 1'b1;
  int echo_at  = NONE;
  int echo_len = 0;

  int errors = 0;
  int checks = 0;

  int   burst_rises = 0;
  int   burst_high  = 0;
  int   done_cnt    = 0;
  logic burst_prev  = 1'b0;

  telemetre_sequencer_if #(.CNT_W(CW)) bus ();

  telemetre_sequencer #(
    .BURST_PULSES(BP),
    .BLANK_CYCLES(BLANK),
    .TIMEOUT     (TO),
    .CNT_W       (CW)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  function automatic bit frq_at(input int c);
    return frq_en && (((c + phase) % PER) < HI);
  endfunction

  function automatic int first_rise(input int a);
    for (int c = a - 1; c < a + 2 * PER; c++)
      if (frq_at(c) && !frq_at(c - 1)) return c;
    return -1;
  endfunction

  // Reference result for an echo pin edge m cycles after the burst start c0.
  // A negative m means that no echo is sent.
  function automatic void model(input int m, input int c0, output logic [CW-1:0] et,
                                output logic to, output int done_cyc);
    if (m >= LISTEN_OPEN && m <= TO) begin
      et = CW'(m); to = 1'b0; done_cyc = c0 + SYNC + m + 1;
    end else begin
      et = CW'(TO); to = 1'b1; done_cyc = c0 + SYNC + TO + 1;
    end
  endfunction

  // Pin drivers: the value during cycle c is set just after posedge c.
  always @(posedge Clk) begin
    cyc++;
    #1;
    bus.Frq_in = frq_at(cyc);
    bus.Echo   = (cyc >= echo_at) && (cyc < echo_at + echo_len);
  end

  always @(negedge Clk) begin
    if (bus.Burst_out === 1'b1 && burst_prev !== 1'b1) burst_rises++;
    if (bus.Burst_out === 1'b1) burst_high++;
    burst_prev = bus.Burst_out;
    if (bus.Done === 1'b1) done_cnt++;
  end

  // Runs one measurement and collects what the DUT reports; no judging here.
  task automatic measure(input int m, input int w, input int restart_off, input bit hold,
                         output int a, output int c0, output bit got, output int done_cyc,
                         output logic [CW-1:0] et, output logic to, output logic busy_a,
                         output logic busy_a1, output logic busy_done, output int rises,
                         output int high, output int dones);
    int r0, h0, d0;
    @(posedge Clk); #1;
    a = cyc;
    bus.Start = 1'b1;
    c0 = first_rise(a);
    echo_len = w;
    echo_at = (m >= 0 && c0 >= 0) ? c0 + m : NONE;
    r0 = burst_rises; h0 = burst_high; d0 = done_cnt;
    got = 1'b0; done_cyc = -1; et = '0; to = 1'b0; busy_done = 1'b0; busy_a1 = 1'b0;
    @(negedge Clk);
    busy_a = bus.Busy;
    for (int i = 0; i < 600 && !got; i++) begin
      @(posedge Clk); #1;
      bus.Start = hold || (restart_off >= 0 && cyc == a + restart_off);
      @(negedge Clk);
      if (i == 0) busy_a1 = bus.Busy;
      if (bus.Done === 1'b1) begin
        got = 1'b1; done_cyc = cyc; et = bus.Echo_time; to = bus.Timeout; busy_done = bus.Busy;
      end
    end
    #1;
    rises = burst_rises - r0; high = burst_high - h0; dones = done_cnt - d0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.Burst_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_burst: got %b expected 0", bus.Burst_out); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b expected 0", bus.Done); end
    checks++; if (bus.Timeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_timeout: got %b expected 0", bus.Timeout); end
    checks++; if (bus.Echo_time !== '0) begin errors++; $display("[TB] FAIL rst_echo_time: got %0d expected 0", bus.Echo_time); end
    repeat (3) @(posedge Clk);
    @(negedge Clk); Rst_n = 1'b1;
    @(negedge Clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_busy: got %b expected 0", bus.Busy); end
  endtask

  task automatic test_nominal();
    int a, c0, dc, rises, high, dones, exp_done; bit got;
    logic [CW-1:0] et, exp_et; logic to, exp_to, ba, ba1, bd;
    phase = 3;
    repeat (3) @(posedge Clk);
    measure(120, 10, -1, 1'b0, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
    model(120, c0, exp_et, exp_to, exp_done);
    checks++; if (!got) begin errors++; $display("[TB] FAIL nom_done_seen: got 0 expected 1"); end
    checks++; if (et !== exp_et) begin errors++; $display("[TB] FAIL nom_echo_time: got %0d expected %0d", et, exp_et); end
    checks++; if (to !== exp_to) begin errors++; $display("[TB] FAIL nom_timeout: got %b expected %b", to, exp_to); end
    checks++; if (dc != exp_done) begin errors++; $display("[TB] FAIL nom_done_cycle: got %0d expected %0d", dc, exp_done); end
    checks++; if (rises != BP) begin errors++; $display("[TB] FAIL nom_burst_pulses: got %0d expected %0d", rises, BP); end
    checks++; if (high != BP * HI) begin errors++; $display("[TB] FAIL nom_burst_high: got %0d expected %0d", high, BP * HI); end
    checks++; if (ba !== 1'b0) begin errors++; $display("[TB] FAIL nom_busy_idle: got %b expected 0", ba); end
    checks++; if (ba1 !== 1'b1) begin errors++; $display("[TB] FAIL nom_busy_arm: got %b expected 1", ba1); end
    checks++; if (bd !== 1'b1) begin errors++; $display("[TB] FAIL nom_busy_done: got %b expected 1", bd); end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL nom_done_pulses: got %0d expected 1", dones); end
  endtask

  task automatic test_reset_mid_burst();
    bit found; int h0;
    @(posedge Clk); #1; bus.Start = 1'b1;
    @(posedge Clk); #1; bus.Start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge Clk);
      if (bus.Burst_out === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL mid_burst_seen: got 0 expected 1"); end
    #2; Rst_n = 1'b0;
    #1;
    checks++; if (bus.Burst_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_burst: got %b expected 0", bus.Burst_out); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_done: got %b expected 0", bus.Done); end
    checks++; if (bus.Timeout !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_timeout: got %b expected 0", bus.Timeout); end
    checks++; if (bus.Echo_time !== '0) begin errors++; $display("[TB] FAIL mid_rst_echo_time: got %0d expected 0", bus.Echo_time); end
    echo_at = NONE;
    @(negedge Clk); Rst_n = 1'b1;
    #1; h0 = burst_high;
    repeat (15) @(negedge Clk);
    #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_idle: got %b expected 0", bus.Busy); end
    checks++; if (burst_high != h0) begin errors++; $display("[TB] FAIL mid_rst_quiet: got %0d expected %0d", burst_high - h0, 0); end
  endtask

  task automatic test_blanking();
    int a, c0, dc, rises, high, dones, exp_done; bit got;
    logic [CW-1:0] et, exp_et; logic to, exp_to, ba, ba1, bd;
    phase = $urandom_range(0, PER - 1);
    repeat (3) @(posedge Clk);
    measure(45, 5, -1, 1'b0, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
    model(-1, c0, exp_et, exp_to, exp_done);
    checks++; if (!got) begin errors++; $display("[TB] FAIL blank_done_seen: got 0 expected 1"); end
    checks++; if (et !== exp_et) begin errors++; $display("[TB] FAIL blank_echo_time: got %0d expected %0d", et, exp_et); end
    checks++; if (to !== 1'b1) begin errors++; $display("[TB] FAIL blank_timeout: got %b expected 1", to); end
    checks++; if (dc != exp_done) begin errors++; $display("[TB] FAIL blank_done_cycle: got %0d expected %0d", dc, exp_done); end
  endtask

  task automatic test_carrier_dead();
    int a, c0, dc, rises, high, dones; bit got;
    logic [CW-1:0] et; logic to, ba, ba1, bd;
    frq_en = 1'b0;
    repeat (3) @(posedge Clk);
    measure(-1, 0, -1, 1'b0, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
    checks++; if (!got) begin errors++; $display("[TB] FAIL dead_done_seen: got 0 expected 1"); end
    checks++; if (to !== 1'b1) begin errors++; $display("[TB] FAIL dead_timeout: got %b expected 1", to); end
    checks++; if (et !== CW'(TO)) begin errors++; $display("[TB] FAIL dead_echo_time: got %0d expected %0d", et, TO); end
    checks++; if (dc != a + 1 + TO + 1) begin errors++; $display("[TB] FAIL dead_done_cycle: got %0d expected %0d", dc, a + TO + 2); end
    checks++; if (rises != 0) begin errors++; $display("[TB] FAIL dead_burst: got %0d expected 0", rises); end
    frq_en = 1'b1;
  endtask

  task automatic test_restart_ignored();
    int a, c0, dc, rises, high, dones, exp_done, d0; bit got;
    logic [CW-1:0] et, exp_et; logic to, exp_to, ba, ba1, bd;
    phase = 7;
    repeat (3) @(posedge Clk);
    d0 = done_cnt;
    measure(150, 8, 100, 1'b0, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
    model(150, c0, exp_et, exp_to, exp_done);
    checks++; if (et !== exp_et) begin errors++; $display("[TB] FAIL restart_echo_time: got %0d expected %0d", et, exp_et); end
    checks++; if (to !== exp_to) begin errors++; $display("[TB] FAIL restart_timeout: got %b expected %b", to, exp_to); end
    repeat (30) @(negedge Clk);
    #1;
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("[TB] FAIL restart_single_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_idle: got %b expected 0", bus.Busy); end
  endtask

  task automatic test_back_to_back();
    int a, c0, dc, rises, high, dones, exp_done; bit got;
    logic [CW-1:0] et, exp_et; logic to, exp_to, ba, ba1, bd;
    phase = 1;
    repeat (3) @(posedge Clk);
    measure(80, 5, -1, 1'b1, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
    model(80, c0, exp_et, exp_to, exp_done);
    checks++; if (et !== exp_et || dc != exp_done) begin errors++; $display("[TB] FAIL b2b_first: got %0d@%0d expected %0d@%0d", et, dc, exp_et, exp_done); end
    measure(150, 5, -1, 1'b0, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
    model(150, c0, exp_et, exp_to, exp_done);
    checks++; if (ba !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %b expected 0", ba); end
    checks++; if (ba1 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_restart: got %b expected 1", ba1); end
    checks++; if (et !== exp_et) begin errors++; $display("[TB] FAIL b2b_echo_time: got %0d expected %0d", et, exp_et); end
    checks++; if (dc != exp_done) begin errors++; $display("[TB] FAIL b2b_done_cycle: got %0d expected %0d", dc, exp_done); end
  endtask

  task automatic test_echo_at_timeout();
    int a, c0, dc, rises, high, dones, exp_done; bit got;
    logic [CW-1:0] et, exp_et; logic to, exp_to, ba, ba1, bd;
    for (int m = TO; m <= TO + 1; m++) begin
      phase = $urandom_range(0, PER - 1);
      repeat (3) @(posedge Clk);
      measure(m, 5, -1, 1'b0, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
      model(m, c0, exp_et, exp_to, exp_done);
      checks++; if (et !== exp_et) begin errors++; $display("[TB] FAIL edge_echo_time m=%0d: got %0d expected %0d", m, et, exp_et); end
      checks++; if (to !== exp_to) begin errors++; $display("[TB] FAIL edge_timeout m=%0d: got %b expected %b", m, to, exp_to); end
      checks++; if (dc != exp_done) begin errors++; $display("[TB] FAIL edge_done_cycle m=%0d: got %0d expected %0d", m, dc, exp_done); end
    end
  endtask

  task automatic test_random();
    int a, c0, dc, rises, high, dones, exp_done, m, w, kind; bit got;
    logic [CW-1:0] et, exp_et; logic to, exp_to, ba, ba1, bd;
    for (int it = 0; it < 8; it++) begin
      phase = $urandom_range(0, PER - 1);
      repeat (3) @(posedge Clk);
      kind = $urandom_range(0, 3);
      if (kind <= 1) begin m = $urandom_range(LISTEN_OPEN, TO + 5); w = $urandom_range(1, 20); end
      else if (kind == 2) begin m = $urandom_range(10, LISTEN_OPEN - 1); w = $urandom_range(1, 40); end
      else begin m = -1; w = 0; end
      measure(m, w, -1, 1'b0, a, c0, got, dc, et, to, ba, ba1, bd, rises, high, dones);
      model(m, c0, exp_et, exp_to, exp_done);
      checks++; if (!got) begin errors++; $display("[TB] FAIL rnd%0d_done_seen: got 0 expected 1", it); end
      checks++; if (et !== exp_et) begin errors++; $display("[TB] FAIL rnd%0d_echo_time m=%0d w=%0d: got %0d expected %0d", it, m, w, et, exp_et); end
      checks++; if (to !== exp_to) begin errors++; $display("[TB] FAIL rnd%0d_timeout m=%0d w=%0d: got %b expected %b", it, m, w, to, exp_to); end
      checks++; if (dc != exp_done) begin errors++; $display("[TB] FAIL rnd%0d_done_cycle: got %0d expected %0d", it, dc, exp_done); end
      checks++; if (rises != BP) begin errors++; $display("[TB] FAIL rnd%0d_burst_pulses: got %0d expected %0d", it, rises, BP); end
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.Start  = 1'b0;
    bus.Frq_in = 1'b0;
    bus.Echo   = 1'b0;
    test_reset();
    test_nominal();
    test_reset_mid_burst();
    test_blanking();
    test_carrier_dead();
    test_restart_ignored();
    test_back_to_back();
    test_echo_at_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
